alu_mbyte_seq: RTL and testbench
================================

Name: alu_mbyte_seq

Overview:
Multi-precision add/subtract sequencer for the 8-bit ALU arithmetic path. It processes an NBYTES-wide operation one byte per cycle, LSB first. Each cycle it drives the operand-conditioning stage (A/B pass-through, B inversion and carry selection on S/cin) and registers the 8-bit adder result. It chains the carry between bytes, then reports the full result, the final carry/borrow and a zero flag.

Parameters:
NBYTES, 4, number of 8-bit bytes per operand; legal range 1..16.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; synchronous, active-high.
start  in  1  request a new operation; sampled only in IDLE.
op  in  2  00 ADD, 01 ADDC, 10 SUB, 11 SUBC; same encoding as the conditioning-stage S select.
cin  in  1  carry/borrow in; used by ADDC/SUBC only.
a  in  8*NBYTES  operand A.
b  in  8*NBYTES  operand B.
alu_a  out  8  current A byte to the conditioning stage.
alu_b  out  8  current B byte to the conditioning stage.
alu_s  out  2  S select to the conditioning stage.
alu_cin  out  1  cin to the conditioning stage.
alu_sum  in  8  adder sum, combinational from alu_a/alu_b/alu_s/alu_cin.
alu_cout  in  1  raw adder carry-out, combinational.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse; result, cout and zero are valid from this cycle.
result  out  8*NBYTES  registered result.
cout  out  1  ADD/ADDC: raw carry out of the MSB. SUB/SUBC: borrow (inverted raw carry).
zero  out  1  high when result == 0.

Behaviour:
- Reset (rst=1 at a clk edge): state goes to IDLE. All outputs are 0: busy, done, result, cout, zero, alu_a, alu_b, alu_s and alu_cin. Reset in mid-operation aborts it; no done is issued.
- States: IDLE, RUN, DONE.
- IDLE: if start=1, latch a, b, op and cin, clear byte index idx to 0, and go to RUN. If start=0, stay in IDLE.
- RUN: one byte per cycle, idx = 0..NBYTES-1.
  - alu_a = a_lat[8*idx +: 8]; alu_b = b_lat[8*idx +: 8].
  - idx=0: alu_s = op_lat, alu_cin = cin_lat.
  - idx>0, add family (op_lat[1]=0): alu_s = 01, alu_cin = carry_reg.
  - idx>0, sub family (op_lat[1]=1): alu_s = 11, alu_cin = ~carry_reg. The effective adder carry-in is therefore carry_reg.
  - At each edge: result[8*idx +: 8] <= alu_sum; carry_reg <= alu_cout; idx <= idx+1.
  - After the idx=NBYTES-1 edge, go to DONE.
- DONE: lasts one cycle with done=1 and busy=0, then returns to IDLE.
  - cout = carry_reg for the add family, ~carry_reg for the sub family.
  - zero = (result == 0).
  - A start asserted during DONE is ignored.
- Outside RUN, alu_a, alu_b, alu_s and alu_cin are all 0.
- Latency: start accepted at edge T; done is high in the cycle after edge T+NBYTES. That is NBYTES+1 cycles from start to done. Back-to-back operations: the next start is accepted at the first IDLE cycle after done.
- busy = 1 in RUN only.
- start is ignored while busy; latched operands do not change during RUN.
- result, cout and zero hold their values until the next operation's first RUN edge. Partial results may then be visible; they are valid only at done.
- idx has width clog2(NBYTES)+1 and never wraps within one operation.
- NBYTES=1: RUN lasts a single cycle; the idx>0 rules are unused.

Test Plan:
(The bench models the conditioning stage plus an 8-bit adder on the alu_* ports; NBYTES=4.)
- ADD a=0x000000FF, b=0x00000001 -> result=0x00000100, cout=0, zero=0. done is exactly 5 cycles after start, and busy is high for 4 cycles.
- SUB a=0x00000000, b=0x00000001 -> result=0xFFFFFFFF, cout=1 (borrow), zero=0. During RUN, alu_s sequence is 10,11,11,11.
- ADDC a=0xFFFFFFFF, b=0x00000000, cin=1 -> result=0x00000000, cout=1, zero=1. SUBC a=0x00000005, b=0x00000005, cin=1 -> result=0xFFFFFFFF, cout=1.
- start held high continuously with new operands applied during RUN -> the first operation's result is unaffected. The second operation starts at the first IDLE cycle after done.
- rst pulsed while idx=2 -> the next cycle is IDLE with all outputs 0 and no done pulse. A fresh ADD 0x12345678+0x11111111 afterwards gives 0x23456789, cout=0.

Source files
------------

// File: rtl/alu_mbyte_seq.sv
// alu_mbyte_seq: multi-byte add/subtract sequencer driving an external 8-bit conditioning stage and adder, LSB first
module alu_mbyte_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic                cin,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [1:0]          alu_s,
  output logic                alu_cin,
  input  logic [7:0]          alu_sum,
  input  logic                alu_cout,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                zero
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [W-1:0] a_lat, b_lat, res_nxt;
  logic [1:0] op_lat;
  logic cin_lat, carry_reg, run, last;
  logic [IW-1:0] idx;
  always_comb begin
    run = state == RUN;
    last = idx == IW'(NBYTES - 1);
    state_nxt = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    res_nxt = result;
    res_nxt[8*idx +: 8] = alu_sum;
    alu_a = run ? a_lat[8*idx +: 8] : '0;
    alu_b = run ? b_lat[8*idx +: 8] : '0;
    // Upper bytes chain the stored carry; the sub family's S=11 re-inverts it, so the adder sees carry_reg
    alu_s = !run ? 2'b00 : idx == '0 ? op_lat : {op_lat[1], 1'b1};
    alu_cin = !run ? 1'b0 : idx == '0 ? cin_lat : carry_reg ^ op_lat[1];
    busy = run;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_lat <= '0;
      b_lat <= '0;
      op_lat <= '0;
      cin_lat <= 1'b0;
      carry_reg <= 1'b0;
      idx <= '0;
      result <= '0;
      cout <= 1'b0;
      zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        a_lat <= a;
        b_lat <= b;
        op_lat <= op;
        cin_lat <= cin;
        idx <= '0;
      end
      if (run) begin
        result <= res_nxt;
        carry_reg <= alu_cout;
        idx <= idx + 1'b1;
        if (last) begin
          cout <= alu_cout ^ op_lat[1];
          zero <= res_nxt == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_mbyte_seq.sv
// tb_alu_mbyte_seq: randomized and directed checks of alu_mbyte_seq against a word-level arithmetic model
module tb_alu_mbyte_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic [7:0] alu_a, alu_b, alu_sum, bb;
  logic [1:0] alu_s;
  logic alu_cin, alu_cout, busy, done, cout, zero, cc;
  logic [31:0] result;
  int pass_cnt = 0, total = 0;
  always #5 clk = ~clk;
  alu_mbyte_seq #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin), .a(a), .b(b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_sum(alu_sum), .alu_cout(alu_cout), .busy(busy), .done(done),
    .result(result), .cout(cout), .zero(zero)
  );
  // Conditioning stage plus 8-bit adder: S=00 A+B, 01 A+B+cin, 10 A+~B+1, 11 A+~B+~cin
  always_comb begin
    bb = alu_s[1] ? ~alu_b : alu_b;
    cc = alu_s == 2'b00 ? 1'b0 : alu_s == 2'b01 ? alu_cin : alu_s == 2'b10 ? 1'b1 : ~alu_cin;
    {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, bb} + {8'd0, cc};
  end
  function automatic void model(input logic [1:0] o, input logic ci, input logic [31:0] x, y,
                                output logic [31:0] r, output logic co);
    longint ax = longint'(x), by = longint'(y), t;
    case (o)
      2'b00: t = ax + by;
      2'b01: t = ax + by + longint'(ci);
      2'b10: t = ax - by;
      default: t = ax - by - longint'(ci);
    endcase
    r = t[31:0];
    co = o[1] ? (t < 0) : (t > 64'hFFFF_FFFF);
  endfunction
  task automatic run_op(input logic [1:0] o, input logic ci, input logic [31:0] x, y, input bit hold,
                        output logic [31:0] r, output logic co, z, output int lat, busy_n,
                        output logic [7:0] s_seq);
    bit seen = 0;
    @(posedge clk); #1;
    start = 1; op = o; cin = ci; a = x; b = y;
    lat = 0; busy_n = 0; s_seq = '0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (!hold) start = 0;
      else begin a = $urandom; b = $urandom; op = 2'($urandom); cin = 1'($urandom); end
      lat++;
      if (busy) begin busy_n++; s_seq = {s_seq[5:0], alu_s}; end
      seen = done;
    end
    r = result; co = cout; z = zero;
    if (!seen) begin total++; $display("FAIL timeout: done never seen, got %0b want 1", done); end
  endtask
  task automatic check_op(input string nm, input logic [1:0] o, input logic ci, input logic [31:0] x, y);
    logic [31:0] r, er; logic co, z, eco; int lat, bn; logic [7:0] ss;
    run_op(o, ci, x, y, 0, r, co, z, lat, bn, ss);
    model(o, ci, x, y, er, eco);
    total++;
    if ({r, co, z} !== {er, eco, er == 0}) $display("FAIL %s: got r=%h c=%b z=%b want r=%h c=%b z=%b", nm, r, co, z, er, eco, er == 0);
    else pass_cnt++;
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, result, cout, zero, alu_a, alu_b, alu_s, alu_cin} !== '0)
      $display("FAIL reset: got busy=%b done=%b r=%h c=%b z=%b a=%h b=%h s=%b ci=%b want all 0", busy, done, result, cout, zero, alu_a, alu_b, alu_s, alu_cin);
    else pass_cnt++;
    rst = 0;
  endtask
  task automatic test_add;
    logic [31:0] r; logic co, z; int lat, bn; logic [7:0] ss;
    run_op(2'b00, 0, 32'h0000_00FF, 32'h0000_0001, 0, r, co, z, lat, bn, ss);
    total++;
    if ({r, co, z} !== {32'h0000_0100, 1'b0, 1'b0}) $display("FAIL add: got r=%h c=%b z=%b want r=00000100 c=0 z=0", r, co, z);
    else pass_cnt++;
    total++;
    if (lat !== 5) $display("FAIL add_latency: got %0d want 5", lat); else pass_cnt++;
    total++;
    if (bn !== 4) $display("FAIL add_busy_cycles: got %0d want 4", bn); else pass_cnt++;
  endtask
  task automatic test_sub;
    logic [31:0] r; logic co, z; int lat, bn; logic [7:0] ss;
    run_op(2'b10, 0, 32'h0, 32'h1, 0, r, co, z, lat, bn, ss);
    total++;
    if ({r, co, z} !== {32'hFFFF_FFFF, 1'b1, 1'b0}) $display("FAIL sub: got r=%h c=%b z=%b want r=ffffffff c=1 z=0", r, co, z);
    else pass_cnt++;
    total++;
    if (ss !== 8'b10_11_11_11) $display("FAIL sub_s_seq: got %b want 10111111", ss); else pass_cnt++;
  endtask
  task automatic test_carry;
    logic [31:0] r; logic co, z; int lat, bn; logic [7:0] ss;
    run_op(2'b01, 1, 32'hFFFF_FFFF, 32'h0, 0, r, co, z, lat, bn, ss);
    total++;
    if ({r, co, z} !== {32'h0, 1'b1, 1'b1}) $display("FAIL addc: got r=%h c=%b z=%b want r=00000000 c=1 z=1", r, co, z);
    else pass_cnt++;
    run_op(2'b11, 1, 32'h5, 32'h5, 0, r, co, z, lat, bn, ss);
    total++;
    if ({r, co, z} !== {32'hFFFF_FFFF, 1'b1, 1'b0}) $display("FAIL subc: got r=%h c=%b z=%b want r=ffffffff c=1 z=0", r, co, z);
    else pass_cnt++;
  endtask
  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      logic [31:0] x = $urandom, y = $urandom;
      if (i % 4 == 1) y = x;
      if (i % 4 == 2) y = x + 32'(i % 3) - 1;
      check_op("random", 2'($urandom), 1'($urandom), x, y);
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] r, er; logic co, z, eco; int lat, bn; logic [7:0] ss; bit seen = 0;
    run_op(2'b10, 1, 32'h1234_0000, 32'h0000_0001, 1, r, co, z, lat, bn, ss);
    model(2'b10, 1, 32'h1234_0000, 32'h0000_0001, er, eco);
    total++;
    if ({r, co} !== {er, eco}) $display("FAIL held_first: got r=%h c=%b want r=%h c=%b", r, co, er, eco);
    else pass_cnt++;
    @(posedge clk); #1;
    total++;
    if ({busy, done} !== 2'b00) $display("FAIL held_idle: got busy/done=%b want 00", {busy, done}); else pass_cnt++;
    op = 2'b00; cin = 0; a = 32'h0F0F_0F0F; b = 32'h0101_0101;
    @(posedge clk); #1;
    start = 0;
    total++;
    if (busy !== 1'b1) $display("FAIL held_second_start: got busy=%b want 1", busy); else pass_cnt++;
    for (int i = 0; i < 10 && !seen; i++) begin @(posedge clk); #1; seen = done; end
    total++;
    if (!seen || result !== 32'h1010_1010 || cout !== 1'b0)
      $display("FAIL held_second: got done=%b r=%h c=%b want done=1 r=10101010 c=0", seen, result, cout);
    else pass_cnt++;
  endtask
  task automatic test_reset_mid;
    bit seen = 0;
    @(posedge clk); #1;
    start = 1; op = 2'b00; cin = 0; a = 32'hFFFF_FFFF; b = 32'h1;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    total++;
    if ({busy, done, result, cout, zero, alu_a, alu_b, alu_s, alu_cin} !== '0)
      $display("FAIL reset_mid: got busy=%b done=%b r=%h c=%b z=%b a=%h b=%h s=%b ci=%b want all 0", busy, done, result, cout, zero, alu_a, alu_b, alu_s, alu_cin);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; seen = seen | done | busy; end
    total++;
    if (seen) $display("FAIL reset_mid_quiet: got activity=1 want 0"); else pass_cnt++;
    check_op("after_reset_add", 2'b00, 0, 32'h1234_5678, 32'h1111_1111);
  endtask
  initial begin
    test_reset;
    test_add;
    test_sub;
    test_carry;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
